// File: rtl/frame_tick_scheduler.sv
// frame_tick_scheduler: paces the game tick (sync), waits a settle window,
// then rasters the (x,y) cell-query bus over the grid once per tick under a
// valid/ready handshake. Handles pause, speed selection, overrun and halt.
module frame_tick_scheduler #(
    parameter int TICK_CYCLES   = 1500000,
    parameter int SETTLE_CYCLES = 4,
    parameter int GRID_W        = 16,
    parameter int GRID_H        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic [1:0] speed_sel,
    input  logic       game_over,
    input  logic       restart,
    input  logic       cell_ready,
    output logic       sync,
    output logic       cell_valid,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       frame_done,
    output logic       overrun,
    output logic [7:0] frame_count,
    output logic [2:0] state
);
    localparam int CW = $clog2(TICK_CYCLES + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    X_LAST      = 4'(GRID_W - 1);
    localparam logic [3:0]    Y_LAST      = 4'(GRID_H - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        UPDATE    = 3'd2,
        SETTLE    = 3'd3,
        SCAN      = 3'd4,
        DONE      = 3'd5,
        HALT      = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          pend_q, pend_d;
    logic          sync_q, sync_d;
    logic          valid_q, valid_d;
    logic [3:0]    x_q, x_d;
    logic [3:0]    y_q, y_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    fc_q, fc_d;

    logic [CW-1:0] period_sel;
    logic          run;
    logic          expire;

    assign period_sel = CW'(TICK_CYCLES >> speed_sel);

    // Tick counter runs in every active state; WAIT_TICK with game_over halts instead of counting
    assign run    = (state_q inside {WAIT_TICK, UPDATE, SETTLE, SCAN, DONE}) && !pause &&
                    !(state_q == WAIT_TICK && game_over);
    assign expire = run && (cnt_q == period_q - CW'(1));

    // Next-state, counter, raster and bookkeeping logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        settle_d = settle_q;
        pend_d   = pend_q;
        x_d      = x_q;
        y_d      = y_q;
        ovr_d    = ovr_q;
        fc_d     = fc_q;

        if (run) cnt_d = cnt_q + CW'(1);
        // Period reloads from speed_sel only when the counter clears, so a
        // mid-period speed change applies to the following period.
        if (expire) begin
            cnt_d    = '0;
            period_d = period_sel;
            if (state_q != WAIT_TICK) begin
                pend_d = 1'b1;
                ovr_d  = 1'b1;
            end
        end

        case (state_q)
            IDLE: state_d = WAIT_TICK;
            WAIT_TICK: begin
                if (game_over) begin
                    state_d = HALT;
                    cnt_d   = '0;
                end else if (expire) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = SCAN;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            SCAN: begin
                if (cell_ready) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            fc_d    = fc_q + 8'd1;
                            state_d = DONE;
                        end else begin
                            y_d = y_q + 4'd1;
                        end
                    end else begin
                        x_d = x_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (game_over) begin
                    state_d = HALT;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (pend_q || expire) begin
                    state_d = UPDATE;
                    pend_d  = 1'b0;
                end else begin
                    state_d = WAIT_TICK;
                end
            end
            HALT: begin
                cnt_d  = '0;
                pend_d = 1'b0;
                if (restart) begin
                    state_d  = WAIT_TICK;
                    ovr_d    = 1'b0;
                    fc_d     = '0;
                    period_d = period_sel;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pulses/valid are registered copies of the next state, so they line
        // up exactly with the state they belong to.
        sync_d  = (state_d == UPDATE);
        valid_d = (state_d == SCAN);
        done_d  = (state_d == DONE);
    end

    // State and output registers; reset clears everything, cell_valid drops at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= CW'(TICK_CYCLES);
            settle_q <= '0;
            pend_q   <= 1'b0;
            sync_q   <= 1'b0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            fc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            settle_q <= settle_d;
            pend_q   <= pend_d;
            sync_q   <= sync_d;
            valid_q  <= valid_d;
            x_q      <= x_d;
            y_q      <= y_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            fc_q     <= fc_d;
        end
    end

    assign sync        = sync_q;
    assign cell_valid  = valid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_done  = done_q;
    assign overrun     = ovr_q;
    assign frame_count = fc_q;
    assign state       = state_q;

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// Bench for frame_tick_scheduler: cell-order scoreboard (filled at each sync,
// drained on each accepted handshake) plus timing checks on tick pacing,
// stalls, pause, overrun, halt/restart, speed change and async reset.
module tb_frame_tick_scheduler;
    localparam int TICK    = 300;
    localparam int SETTLE  = 4;
    localparam int GW      = 16;
    localparam int GH      = 16;
    localparam int NCELL   = GW * GH;
    localparam int ST_IDLE = 0;
    localparam int ST_WAIT = 1;
    localparam int ST_HALT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic       game_over = 1'b0;
    logic       restart = 1'b0;
    logic       cell_ready = 1'b1;
    logic       sync, cell_valid, frame_done, overrun;
    logic [3:0] x, y;
    logic [7:0] frame_count;
    logic [2:0] state;

    int cyc = 0;
    int n_chk = 0;
    int n_bad = 0;
    logic [7:0] sb_q[$];

    frame_tick_scheduler #(
        .TICK_CYCLES(TICK), .SETTLE_CYCLES(SETTLE), .GRID_W(GW), .GRID_H(GH)
    ) dut (
        .clk(clk), .rst(rst), .pause(pause), .speed_sel(speed_sel),
        .game_over(game_over), .restart(restart), .cell_ready(cell_ready),
        .sync(sync), .cell_valid(cell_valid), .x(x), .y(y),
        .frame_done(frame_done), .overrun(overrun),
        .frame_count(frame_count), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // kind 0 = sync, 1 = cell_valid, 2 = frame_done; at = -1 if the bound expires
    task automatic wait_ev(input int kind, input int max, output int at);
        at = -1;
        for (int i = 0; i < max && at < 0; i++) begin
            @(negedge clk);
            if ((kind == 0 && sync) || (kind == 1 && cell_valid) || (kind == 2 && frame_done))
                at = cyc;
        end
    endtask

    task automatic wait_cell(input int xx, input int yy, input int max, output int found);
        found = 0;
        for (int i = 0; i < max && found == 0; i++) begin
            @(negedge clk);
            if (cell_valid && x == 4'(xx) && y == 4'(yy)) found = 1;
        end
    endtask

    // Scoreboard: each sync queues the full raster; each accepted cell pops one
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (sync) begin
                chk("sync_with_valid", int'(cell_valid), 0);
                chk("sb_left_at_sync", sb_q.size(), 0);
                for (int yy = 0; yy < GH; yy++)
                    for (int xx = 0; xx < GW; xx++)
                        sb_q.push_back(8'(yy * 16 + xx));
            end
            if (cell_valid && cell_ready) begin
                chk("sb_has_entry", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) chk("cell_yx", int'({y, x}), int'(sb_q.pop_front()));
            end
            if (frame_done) chk("sb_left_at_done", sb_q.size(), 0);
        end
    end

    initial begin
        int c0, r0, s1, s2, s3, s4, s5, s6, s7, s8, t, t2, found;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", int'(state), ST_IDLE);
        chk("rst_outs", int'({sync, cell_valid, x, y, frame_done, overrun, frame_count}), 0);
        @(posedge clk); #1 rst = 1'b0; c0 = cyc;

        // basic frame timing, ready tied high
        wait_ev(0, 1000, s1); chk("first_sync", s1 - c0, TICK + 1);
        wait_ev(1, 50, t);    chk("first_cell_lat", t - s1, SETTLE + 1);
        chk("first_cell_xy", int'({x, y}), 0);
        wait_ev(2, 1000, t);  chk("scan_len", t - s1, SETTLE + 1 + NCELL);
        chk("fc1", int'(frame_count), 1);
        chk("ovr1", int'(overrun), 0);
        wait_ev(0, 1000, s2); chk("tick_intvl", s2 - s1, TICK);

        // 3-cycle stall at (5,2)
        wait_cell(4, 2, 400, found); chk("reach_4_2", found, 1);
        @(posedge clk); #1 cell_ready = 1'b0;
        repeat (3) begin
            @(negedge clk); chk("stall_xy", int'({x, y}), 8'h52);
            @(posedge clk);
        end
        #1 cell_ready = 1'b1;
        wait_ev(2, 1000, t); chk("stall_done", t - s2, SETTLE + 1 + NCELL + 3);
        chk("fc2", int'(frame_count), 2);
        chk("ovr2", int'(overrun), 0);

        // pause in WAIT_TICK stretches the period by 50
        @(posedge clk); #1 pause = 1'b1;
        repeat (50) @(posedge clk);
        #1 pause = 1'b0;
        wait_ev(0, 1000, s3); chk("pause_intvl", s3 - s2, TICK + 50);

        // pause during SCAN does not stretch the scan
        wait_ev(1, 50, t); chk("lat3", t - s3, SETTLE + 1);
        @(posedge clk); #1 pause = 1'b1;
        wait_ev(2, 1000, t2); chk("pause_scan_len", t2 - s3, SETTLE + 1 + NCELL);
        pause = 1'b0;

        // slow consumer (ready 1 of 3): two expirations in one frame, one pending
        wait_ev(0, 2000, s4);
        t = -1;
        for (int i = 0; i < 2000 && t < 0; i++) begin
            @(posedge clk); #1 cell_ready = (i % 3 == 2);
            @(negedge clk);
            if (frame_done) t = cyc;
        end
        chk("ovr_set", int'(overrun), 1);
        @(posedge clk); #1 pause = 1'b1; cell_ready = 1'b1;
        wait_ev(0, 5, s5);    chk("pending_sync", s5 - t, 1);
        wait_ev(2, 1000, t);  chk("f5_len", t - s5, SETTLE + 1 + NCELL);
        chk("fc5", int'(frame_count), 5);
        wait_ev(0, 400, t2);  chk("one_pending_only", t2, -1);
        pause = 1'b0;

        // game_over mid-scan: frame finishes, then HALT with no ticks
        wait_ev(0, 1000, s6);
        wait_cell(3, 7, 400, found); chk("reach_3_7", found, 1);
        @(posedge clk); #1 game_over = 1'b1;
        wait_ev(2, 1000, t); chk("go_scan_len", t - s6, SETTLE + 1 + NCELL);
        chk("fc6", int'(frame_count), 6);
        @(negedge clk); chk("halt_state", int'(state), ST_HALT);
        game_over = 1'b0;
        wait_ev(0, 1000, t2); chk("halt_no_sync", t2, -1);
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0; r0 = cyc;
        @(negedge clk);
        chk("rs_fc", int'(frame_count), 0);
        chk("rs_ovr", int'(overrun), 0);
        chk("rs_state", int'(state), ST_WAIT);
        // restart outside HALT has no effect on the running period
        repeat (50) @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        wait_ev(0, 1000, s7); chk("restart_sync", s7 - r0, TICK);

        // speed change mid-period applies at the next clear
        wait_ev(1, 50, t);
        @(posedge clk); #1 speed_sel = 2'd2;
        wait_ev(0, 1000, s8); chk("old_period", s8 - s7, TICK);
        t = -1;
        for (int i = 0; i < 200 && t < 0; i++) begin
            @(negedge clk);
            if (overrun) t = cyc;
        end
        chk("new_period", t - s8, TICK >> 2);

        // async reset mid-scan
        wait_cell(8, 8, 400, found); chk("reach_8_8", found, 1);
        chk("fc_pre_rst", int'(frame_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", int'({cell_valid, x, y, frame_count}), 0);
        chk("arst_state", int'(state), ST_IDLE);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
